// File: rtl/if_queue_pkg.sv
// Shared constants and types for the instruction-fetch queue.
//   XLEN_WIDTH : width of PC and instruction words.
//   INST_NOP   : instruction word presented to decode when the queue is empty
//                (RV32I canonical NOP, addi x0, x0, 0).
//   entry_t    : one queue slot, {pc, inst}.
package if_queue_pkg;

    localparam int unsigned XLEN_WIDTH = 32;

    localparam logic [XLEN_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_WIDTH-1:0] pc;
        logic [XLEN_WIDTH-1:0] inst;
    } entry_t;

endpackage

// File: rtl/if_queue.sv
// Instruction queue between fetch and decode.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : fetch-side handshake; in_pc/in_inst are the offered entry
//   out_valid/out_ready  : decode-side handshake; out_pc/out_inst show the head entry
//   flush                : drop every entry at the next edge (redirect / mispredict)
//   count                : number of valid entries, 0..DEPTH
// in_ready depends only on the registered count, so a full queue never accepts in
// the same cycle it is popped. Outputs come from storage only (no in->out bypass).
module if_queue
    import if_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [XLEN_WIDTH-1:0]  in_pc,
    input  logic [XLEN_WIDTH-1:0]  in_inst,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [XLEN_WIDTH-1:0]  out_pc,
    output logic [XLEN_WIDTH-1:0]  out_inst,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

    // Storage is never cleared; head/tail/count alone define which slots are live.
    entry_t mem_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW:0]   count_q, count_d;
    logic            push;
    logic            pop;

    assign in_ready  = (count_q != CountFull);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q].pc   <= in_pc;
            mem_q[tail_q].inst <= in_inst;
        end
    end

    always_comb begin
        out_pc   = '0;
        out_inst = INST_NOP;
        if (out_valid) begin
            out_pc   = mem_q[head_q].pc;
            out_inst = mem_q[head_q].inst;
        end
    end

endmodule
